vstu_bresp_tracker: RTL and testbench

Per-instruction write-response tracker for the vector store unit. It records each accepted store instruction, counts the AW bursts the address generator issues on its behalf, and matches incoming AXI B responses to the oldest instruction with outstanding bursts. An instruction retires in order only when its last burst has been issued and all of its bursts are acknowledged. On retirement the tracker raises the `vinsn_done` bit towards the main sequencer and `store_complete` towards the dispatcher.

---
 rtl/vstu_bresp_tracker_pkg.sv | 37 +++
 rtl/vstu_bresp_tracker_if.sv | 27 ++
 rtl/vstu_bresp_tracker.sv | 140 ++++++++++++++
 tb/tb_vstu_bresp_tracker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vstu_bresp_tracker_pkg.sv
// Shared types and helpers for the vector store unit write-response tracker.
// Holds the per-instruction queue entry layout and the default sizing.
package vstu_bresp_tracker_pkg;

  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

  localparam int unsigned VstuNrVInsn         = 32'd8;
  localparam int unsigned VstuBrespQueueDepth = 32'd4;
  localparam int unsigned VstuMaxBursts       = 32'd256;
  localparam int unsigned VstuIdWidth         = idx_width(VstuNrVInsn);
  localparam int unsigned VstuBurstCntWidth   = idx_width(VstuMaxBursts) + 32'd1;

  typedef logic [VstuIdWidth-1:0]       vid_t;
  typedef logic [VstuBurstCntWidth-1:0] burst_cnt_t;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_t;

  typedef struct packed {
    vid_t       id;
    burst_cnt_t issued;
    burst_cnt_t acked;
    logic       last_seen;
    logic       err;
  } bresp_entry_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
  endfunction

endpackage

// File: rtl/vstu_bresp_tracker_if.sv
// Instruction, AW-issue and AXI B handshakes between the store unit and the tracker.
// The master side drives valids/payloads; the tracker (slave) drives the readies.
interface vstu_bresp_tracker_if
  import vstu_bresp_tracker_pkg::*;
#(
  parameter int unsigned NrVInsn = VstuNrVInsn
);
  logic                             insn_valid;
  logic                             insn_ready;
  logic [idx_width(NrVInsn)-1:0]    insn_id;
  logic                             aw_valid;
  logic                             aw_ready;
  logic                             aw_last;
  logic                             b_valid;
  logic                             b_ready;
  logic [1:0]                       b_resp;

  modport master (
    output insn_valid, insn_id, aw_valid, aw_last, b_valid, b_resp,
    input  insn_ready, aw_ready, b_ready
  );

  modport slave (
    input  insn_valid, insn_id, aw_valid, aw_last, b_valid, b_resp,
    output insn_ready, aw_ready, b_ready
  );
endinterface

// File: rtl/vstu_bresp_tracker.sv
// In-order write-response tracker: counts issued AW bursts per store instruction,
// matches B responses to the oldest instruction and retires it once fully acknowledged.
module vstu_bresp_tracker
  import vstu_bresp_tracker_pkg::*;
#(
  parameter int unsigned NrVInsn    = VstuNrVInsn,
  parameter int unsigned QueueDepth = VstuBrespQueueDepth,
  parameter int unsigned MaxBursts  = VstuMaxBursts,
  localparam int unsigned IdW       = idx_width(NrVInsn)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  vstu_bresp_tracker_if.slave  bus,
  output logic [NrVInsn-1:0]   vinsn_done_o,
  output logic                 store_complete_o,
  output logic                 store_pending_o,
  output logic                 error_o,
  output logic [IdW-1:0]       err_id_o
);

  localparam int unsigned PtrW = idx_width(QueueDepth);
  localparam int unsigned OccW = $clog2(QueueDepth + 32'd1);
  localparam int unsigned OutW = $clog2(QueueDepth * MaxBursts + 32'd1);

  bresp_entry_t        entries_r [QueueDepth];
  bresp_entry_t        entries_s [QueueDepth];
  logic [PtrW-1:0]     accept_ptr_r, issue_ptr_r, commit_ptr_r;
  logic [PtrW-1:0]     accept_ptr_s, issue_ptr_s, commit_ptr_s;
  logic [OccW-1:0]     commit_cnt_r, issue_cnt_r, commit_cnt_s, issue_cnt_s;
  logic [OutW-1:0]     outstanding_r, outstanding_s;
  logic [NrVInsn-1:0]  vinsn_done_r, done_vec_s;
  logic                store_complete_r, error_r;
  logic [IdW-1:0]      err_id_r;

  logic                accept_s, aw_fire_s, aw_last_fire_s, b_fire_s, retire_s;
  burst_cnt_t          head_inflight_s;
  bresp_entry_t        head_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(QueueDepth - 32'd1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Readies depend on registered state only, so no valid-to-ready path exists.
  assign head_inflight_s = entries_r[issue_ptr_r].issued - entries_r[issue_ptr_r].acked;
  assign bus.insn_ready  = (commit_cnt_r != OccW'(QueueDepth));
  assign bus.aw_ready    = (issue_cnt_r != '0) && (head_inflight_s != burst_cnt_t'(MaxBursts));
  assign bus.b_ready     = (outstanding_r != '0);

  assign accept_s       = bus.insn_valid && bus.insn_ready;
  assign aw_fire_s      = bus.aw_valid && bus.aw_ready;
  assign aw_last_fire_s = aw_fire_s && bus.aw_last;
  assign b_fire_s       = bus.b_valid && bus.b_ready;

  // Next-state of queue entries, pointers and counts, plus the retirement decision.
  always_comb begin
    entries_s     = entries_r;
    accept_ptr_s  = accept_ptr_r;
    issue_ptr_s   = issue_ptr_r;
    commit_ptr_s  = commit_ptr_r;
    done_vec_s    = '0;

    if (accept_s) begin
      entries_s[accept_ptr_r]    = '0;
      entries_s[accept_ptr_r].id = bus.insn_id;
      accept_ptr_s               = ptr_inc(accept_ptr_r);
    end else begin
      accept_ptr_s = accept_ptr_r;
    end

    if (aw_fire_s) begin
      entries_s[issue_ptr_r].issued = entries_s[issue_ptr_r].issued + burst_cnt_t'(1);
      if (bus.aw_last) begin
        entries_s[issue_ptr_r].last_seen = 1'b1;
        issue_ptr_s                      = ptr_inc(issue_ptr_r);
      end else begin
        issue_ptr_s = issue_ptr_r;
      end
    end else begin
      issue_ptr_s = issue_ptr_r;
    end

    // Bursts are issued in order, so the commit head always owns the oldest unacked burst.
    if (b_fire_s) begin
      entries_s[commit_ptr_r].acked = entries_s[commit_ptr_r].acked + burst_cnt_t'(1);
      entries_s[commit_ptr_r].err   = entries_s[commit_ptr_r].err | resp_is_error(bus.b_resp);
    end else begin
      entries_s[commit_ptr_r].err = entries_s[commit_ptr_r].err;
    end

    head_s   = entries_s[commit_ptr_r];
    retire_s = (commit_cnt_r != '0) && head_s.last_seen && (head_s.acked == head_s.issued);

    if (retire_s) begin
      commit_ptr_s           = ptr_inc(commit_ptr_r);
      done_vec_s[head_s.id]  = 1'b1;
    end else begin
      commit_ptr_s = commit_ptr_r;
    end

    commit_cnt_s  = commit_cnt_r + OccW'(accept_s) - OccW'(retire_s);
    issue_cnt_s   = issue_cnt_r + OccW'(accept_s) - OccW'(aw_last_fire_s);
    outstanding_s = outstanding_r + OutW'(aw_fire_s) - OutW'(b_fire_s);
  end

  // State and registered retirement outputs; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      entries_r        <= '{default: '0};
      accept_ptr_r     <= '0;
      issue_ptr_r      <= '0;
      commit_ptr_r     <= '0;
      commit_cnt_r     <= '0;
      issue_cnt_r      <= '0;
      outstanding_r    <= '0;
      vinsn_done_r     <= '0;
      store_complete_r <= 1'b0;
      error_r          <= 1'b0;
      err_id_r         <= '0;
    end else begin
      entries_r        <= entries_s;
      accept_ptr_r     <= accept_ptr_s;
      issue_ptr_r      <= issue_ptr_s;
      commit_ptr_r     <= commit_ptr_s;
      commit_cnt_r     <= commit_cnt_s;
      issue_cnt_r      <= issue_cnt_s;
      outstanding_r    <= outstanding_s;
      vinsn_done_r     <= done_vec_s;
      store_complete_r <= retire_s;
      error_r          <= retire_s && head_s.err;
      err_id_r         <= retire_s ? head_s.id : err_id_r;
    end
  end

  assign vinsn_done_o     = vinsn_done_r;
  assign store_complete_o = store_complete_r;
  assign store_pending_o  = (commit_cnt_r != '0);
  assign error_o          = error_r;
  assign err_id_o         = err_id_r;

endmodule

// File: tb/tb_vstu_bresp_tracker.sv
// Directed table-driven bench for the write-response tracker, plus hand-written
// sequences for the per-instruction burst limit.
module tb_vstu_bresp_tracker;

  logic       clk;
  logic       rst_n;
  logic [7:0] vinsn_done;
  logic       store_complete;
  logic       store_pending;
  logic       error;
  logic [2:0] err_id;
  int         n_tests;
  int         n_fail;

  vstu_bresp_tracker_if #(.NrVInsn(8)) bif ();

  vstu_bresp_tracker #(
    .NrVInsn    (8),
    .QueueDepth (4),
    .MaxBursts  (256)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bus              (bif.slave),
    .vinsn_done_o     (vinsn_done),
    .store_complete_o (store_complete),
    .store_pending_o  (store_pending),
    .error_o          (error),
    .err_id_o         (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {insn_ready, aw_ready, b_ready, store_pending, store_complete, error, err_id, vinsn_done}
  typedef struct {
    string       name;
    logic        rst_n;
    logic        iv;
    logic [2:0]  id;
    logic        awv;
    logic        awl;
    logic        bv;
    logic [1:0]  br;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rn, input logic iv, input logic [2:0] id,
                     input logic awv, input logic awl, input logic bv, input logic [1:0] br,
                     input logic [3:0] rdy, input logic cpl, input logic err,
                     input logic [2:0] eid, input logic [7:0] done);
    vec_t v;
    v.name = name; v.rst_n = rn; v.iv = iv; v.id = id;
    v.awv = awv; v.awl = awl; v.bv = bv; v.br = br;
    v.exp = {rdy, cpl, err, eid, done};
    vecs.push_back(v);
  endtask

  task automatic cycle(input logic rn, input logic iv, input logic [2:0] id, input logic awv,
                       input logic awl, input logic bv, input logic [1:0] br);
    @(negedge clk);
    rst_n          = rn;
    bif.insn_valid = iv;
    bif.insn_id    = id;
    bif.aw_valid   = awv;
    bif.aw_last    = awl;
    bif.b_valid    = bv;
    bif.b_resp     = br;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    logic [16:0] got;
    cycle(v.rst_n, v.iv, v.id, v.awv, v.awl, v.bv, v.br);
    got = {bif.insn_ready, bif.aw_ready, bif.b_ready, store_pending,
           store_complete, error, err_id, vinsn_done};
    n_tests++;
    if (got !== v.exp) begin
      n_fail++;
      $display("FAIL %s: got %05h required %05h", v.name, got, v.exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bif.insn_valid = 1'b0; bif.insn_id = 3'd0; bif.aw_valid = 1'b0;
    bif.aw_last = 1'b0; bif.b_valid = 1'b0; bif.b_resp = 2'b00;

    //   name             rst   iv   id    awv  awl  bv   br     rdy      cpl  err  eid   done
    add("reset",          1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0, 3'd0, 8'h00);
    add("basic_acc3",     1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd0, 8'h00);
    add("basic_aw0",      1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd0, 8'h00);
    add("basic_aw1_last", 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd0, 8'h00);
    add("basic_b0",       1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd0, 8'h00);
    add("basic_retire3",  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b1, 1'b0, 3'd3, 8'h08);
    add("basic_once",     1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0, 3'd3, 8'h00);
    add("full_acc0",      1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd3, 8'h00);
    add("full_acc1",      1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd3, 8'h00);
    add("full_acc2",      1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd3, 8'h00);
    add("full_acc3",      1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0101, 1'b0, 1'b0, 3'd3, 8'h00);
    add("full_block_aw",  1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0111, 1'b0, 1'b0, 3'd3, 8'h00);
    add("full_retire0",   1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1101, 1'b1, 1'b0, 3'd0, 8'h01);
    add("full_acc4",      1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0101, 1'b0, 1'b0, 3'd0, 8'h00);
    add("wrap_aw1",       1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0111, 1'b0, 1'b0, 3'd0, 8'h00);
    add("wrap_retire1",   1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1101, 1'b1, 1'b0, 3'd1, 8'h02);
    add("wrap_aw2",       1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd1, 8'h00);
    add("wrap_retire2",   1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1101, 1'b1, 1'b0, 3'd2, 8'h04);
    add("wrap_aw3",       1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd2, 8'h00);
    add("wrap_retire3",   1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1101, 1'b1, 1'b0, 3'd3, 8'h08);
    add("wrap_aw4",       1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd3, 8'h00);
    add("wrap_retire4",   1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b1, 1'b0, 3'd4, 8'h10);
    add("sim_acc0",       1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd4, 8'h00);
    add("sim_acc1_aw0",   1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd4, 8'h00);
    add("sim_b_aw_acc",   1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 2'b00, 4'b1111, 1'b1, 1'b0, 3'd0, 8'h01);
    add("sim_aw1_last",   1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd0, 8'h00);
    add("sim_b1a",        1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd0, 8'h00);
    add("sim_retire1",    1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1101, 1'b1, 1'b0, 3'd1, 8'h02);
    add("sim_aw2",        1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd1, 8'h00);
    add("sim_awl_b2",     1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd1, 8'h00);
    add("sim_retire2",    1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b1, 1'b0, 3'd2, 8'h04);
    add("err_acc5",       1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd2, 8'h00);
    add("err_aw0",        1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd2, 8'h00);
    add("err_aw1",        1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd2, 8'h00);
    add("err_awl_slverr", 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 2'b10, 4'b1011, 1'b0, 1'b0, 3'd2, 8'h00);
    add("err_b1_okay",    1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd2, 8'h00);
    add("err_retire5",    1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b1, 1'b1, 3'd5, 8'h20);
    add("err_pulse_once", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0, 3'd5, 8'h00);
    add("dec_acc6",       1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd5, 8'h00);
    add("dec_awl",        1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd5, 8'h00);
    add("dec_retire6",    1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b11, 4'b1000, 1'b1, 1'b1, 3'd6, 8'h40);
    add("exok_acc7",      1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd6, 8'h00);
    add("exok_awl",       1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd6, 8'h00);
    add("exok_retire7",   1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 4'b1000, 1'b1, 1'b0, 3'd7, 8'h80);
    add("bp_acc1_b_idle", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd7, 8'h00);
    // Applied after the burst-limit sequence.
    add("rst_clear",      1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0, 3'd0, 8'h00);
    add("rst_acc2",       1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd0, 8'h00);
    add("rst_acc3_aw",    1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd0, 8'h00);
    add("rst_awl2",       1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd0, 8'h00);
    add("rst_aw3",        1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 3'd0, 8'h00);
    add("rst_midflight",  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b0, 1'b0, 3'd0, 8'h00);
    add("rst_no_done_a",  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b0, 1'b0, 3'd0, 8'h00);
    add("rst_no_done_b",  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0, 3'd0, 8'h00);
    add("post_acc4",      1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 3'd0, 8'h00);
    add("post_awl",       1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1011, 1'b0, 1'b0, 3'd0, 8'h00);
    add("post_retire4",   1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b1, 1'b0, 3'd4, 8'h10);

    for (int i = 0; i < 45; i++) apply(vecs[i]);

    // ID 1 is queued: push it to the 256-outstanding limit, then release one slot with a B.
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00);
      if (i == 254) check1("bp_aw_ready_255", bif.aw_ready, 1'b1);
      if (i == 255) begin
        check1("bp_aw_ready_256", bif.aw_ready, 1'b0);
        check1("bp_b_ready_256", bif.b_ready, 1'b1);
      end
    end
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 2'b00);
    check1("bp_aw_ready_after_b", bif.aw_ready, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00);
    check1("bp_aw_ready_last", bif.aw_ready, 1'b0);
    check1("bp_pending", store_pending, 1'b1);

    for (int i = 45; i < vecs.size(); i++) apply(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
